// File: rtl/matrix_loader.sv
// Matrix loader: captures up to MAX_DIM x MAX_DIM elements in row-major order
// and presents the complete matrix on a flat output buffer until released.
module matrix_loader #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned MAX_DIM    = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            r_in,
    input  logic [2:0]            c_in,
    input  logic                  elem_valid,
    input  logic [DATA_WIDTH-1:0] elem_data,
    // "release" is a reserved word in SystemVerilog, hence the prefix
    input  logic                  mat_release,
    input  logic                  abort,
    output logic                  elem_ready,
    output logic [2:0]            r,
    output logic [2:0]            c,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic [DATA_WIDTH-1:0] data_out_3,
    output logic [DATA_WIDTH-1:0] data_out_4,
    output logic [DATA_WIDTH-1:0] data_out_5,
    output logic [DATA_WIDTH-1:0] data_out_6,
    output logic [DATA_WIDTH-1:0] data_out_7,
    output logic [DATA_WIDTH-1:0] data_out_8,
    output logic [DATA_WIDTH-1:0] data_out_9,
    output logic [DATA_WIDTH-1:0] data_out_10,
    output logic [DATA_WIDTH-1:0] data_out_11,
    output logic [DATA_WIDTH-1:0] data_out_12,
    output logic [DATA_WIDTH-1:0] data_out_13,
    output logic [DATA_WIDTH-1:0] data_out_14,
    output logic [DATA_WIDTH-1:0] data_out_15,
    output logic [DATA_WIDTH-1:0] data_out_16,
    output logic [DATA_WIDTH-1:0] data_out_17,
    output logic [DATA_WIDTH-1:0] data_out_18,
    output logic [DATA_WIDTH-1:0] data_out_19,
    output logic [DATA_WIDTH-1:0] data_out_20,
    output logic [DATA_WIDTH-1:0] data_out_21,
    output logic [DATA_WIDTH-1:0] data_out_22,
    output logic [DATA_WIDTH-1:0] data_out_23,
    output logic [DATA_WIDTH-1:0] data_out_24,
    output logic [4:0]            elem_count,
    output logic                  en,
    output logic                  busy,
    output logic                  dim_err
);

    localparam int unsigned NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned DIM_W    = 3;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned PROD_W   = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DIM_W-1:0]       r_q;
    logic [DIM_W-1:0]       c_q;
    logic [CNT_W-1:0]       count_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   ready_q;
    logic                   dim_err_q;
    logic [DATA_WIDTH-1:0]  mem [NUM_ELEM];

    logic                   dims_ok;
    logic [PROD_W-1:0]      total;
    logic [PROD_W-1:0]      count_inc;
    logic                   load_start;
    logic                   accept;
    logic                   clear_all;
    logic                   dim_err_next;

    assign dims_ok   = (r_in != '0) && (r_in <= DIM_W'(MAX_DIM)) &&
                       (c_in != '0) && (c_in <= DIM_W'(MAX_DIM));
    assign total     = PROD_W'(r_q) * PROD_W'(c_q);
    assign count_inc = PROD_W'(count_q) + PROD_W'(1);

    // Next-state and datapath control; abort overrides every state
    always_comb begin
        state_next   = state;
        load_start   = 1'b0;
        accept       = 1'b0;
        clear_all    = 1'b0;
        dim_err_next = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
            clear_all  = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            load_start = 1'b1;
                            clear_all  = 1'b1;
                            state_next = S_LOAD;
                        end else begin
                            dim_err_next = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (elem_valid) begin
                        accept = 1'b1;
                        if (count_inc == total) begin
                            state_next = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (mat_release) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register; status outputs are decoded from the next state so they
    // line up exactly with the registered state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            dim_err_q <= 1'b0;
        end else begin
            state     <= state_next;
            en_q      <= (state_next == S_VALID);
            busy_q    <= (state_next != S_IDLE);
            ready_q   <= (state_next == S_LOAD);
            dim_err_q <= dim_err_next;
        end
    end

    // Dimensions, element counter and matrix buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (load_start) begin
                r_q <= r_in;
                c_q <= c_in;
            end
            if (clear_all) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + CNT_W'(1);
            end
            for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                if (clear_all) begin
                    mem[k] <= '0;
                end else if (accept && (count_q == CNT_W'(k))) begin
                    mem[k] <= elem_data;
                end
            end
        end
    end

    assign elem_ready  = ready_q;
    assign r           = r_q;
    assign c           = c_q;
    assign elem_count  = count_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign dim_err     = dim_err_q;

    assign data_out_0  = mem[0];
    assign data_out_1  = mem[1];
    assign data_out_2  = mem[2];
    assign data_out_3  = mem[3];
    assign data_out_4  = mem[4];
    assign data_out_5  = mem[5];
    assign data_out_6  = mem[6];
    assign data_out_7  = mem[7];
    assign data_out_8  = mem[8];
    assign data_out_9  = mem[9];
    assign data_out_10 = mem[10];
    assign data_out_11 = mem[11];
    assign data_out_12 = mem[12];
    assign data_out_13 = mem[13];
    assign data_out_14 = mem[14];
    assign data_out_15 = mem[15];
    assign data_out_16 = mem[16];
    assign data_out_17 = mem[17];
    assign data_out_18 = mem[18];
    assign data_out_19 = mem[19];
    assign data_out_20 = mem[20];
    assign data_out_21 = mem[21];
    assign data_out_22 = mem[22];
    assign data_out_23 = mem[23];
    assign data_out_24 = mem[24];

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter: DATA_WIDTH, default 9, element width in bits.
REQ-002 Parameter: MAX_DIM, default 5, maximum rows and maximum columns (fixed at 5 for this block).
REQ-003 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: start, input, 1, begin a new matrix load.
REQ-006 Port: r_in / c_in, input, 3 each, requested row and column counts.
REQ-007 Port: elem_valid, input, 1, element offered.
REQ-008 Port: elem_data, input, DATA_WIDTH, element value.
REQ-009 Port: release, input, 1, downstream finished; drop en.
REQ-010 Port: abort, input, 1, cancel from any state.
REQ-011 Port: elem_ready, output, 1, loader accepts an element this cycle.
REQ-012 Port: r / c, output, 3 each, latched dimensions.
REQ-013 Port: data_out_0 .. data_out_24, output, DATA_WIDTH each, compact row-major matrix buffer.
REQ-014 Port: elem_count, output, 5, elements accepted so far.
REQ-015 Port: en, output, 1, matrix complete and stable.
REQ-016 Port: busy, output, 1, high whenever the state is not IDLE.
REQ-017 Port: dim_err, output, 1, one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD, VALID.
REQ-019 In IDLE, start with r_in and c_in both in 1..5 SHALL:
- latch r and c;
- clear all data_out_k and elem_count to 0;
- enter LOAD on the next edge.
REQ-020 In IDLE, start with r_in or c_in equal to 0 or greater than 5 SHALL:
- pulse dim_err for exactly one cycle;
- leave state, r, c and data_out unchanged.
REQ-021 elem_ready SHALL equal 1 exactly while in LOAD, as a registered-state decode with no combinational path from elem_valid.
REQ-022 On an accept (elem_valid and elem_ready), elem_data SHALL be written to data_out_k with k = elem_count; elem_count SHALL increment; both are visible the following cycle.
REQ-023 Element k SHALL represent row k/c, column k mod c; data_out indices at or above r*c SHALL remain 0.
REQ-024 The accept that brings elem_count to r*c SHALL move the state to VALID; en SHALL be 1 from the next cycle onward, giving a latency of 1 cycle from the last accept to en.
REQ-025 In VALID:
- en SHALL stay 1;
- r, c and data_out SHALL hold stable;
- elem_valid and start SHALL be ignored.
REQ-026 In VALID, release SHALL return the state to IDLE with en = 0 on the next edge; data_out and r/c SHALL hold until the next accepted start.
REQ-027 In IDLE and LOAD, release SHALL be ignored.
REQ-028 In LOAD, start SHALL be ignored.
REQ-029 elem_valid without elem_ready SHALL have no effect.
REQ-030 abort SHALL have priority over every other input in every state. On abort:
- next state IDLE;
- en = 0;
- elem_count = 0;
- all data_out = 0.
REQ-031 elem_count SHALL never exceed r*c; a maximum matrix of 25 elements SHALL fit in 5 bits without wrap.
REQ-032 elem_data SHALL be stored unmodified at full DATA_WIDTH, with no sign or width conversion.

Reset
REQ-033 Assertion of reset_n = 0 SHALL, asynchronously and regardless of clock, force:
- state IDLE;
- en, busy, elem_ready, dim_err = 0;
- r, c, elem_count = 0;
- all data_out = 0.
REQ-034 After reset_n deasserts, the block SHALL respond to start on the first rising edge.
REQ-035 A reset asserted mid-LOAD or mid-VALID SHALL discard the partial or complete matrix entirely.

Verification
REQ-036 Full load: start with r_in=2, c_in=3, then 6 accepts with values 1..6.
- data_out_0..5 = 1..6; data_out_6..24 = 0.
- en=1 exactly one cycle after the 6th accept; r=2, c=3.
REQ-037 Backpressure gaps: 5x5 load with elem_valid low on random cycles.
- Exactly 25 accepts occur; data_out_k = k+100 when element value k+100 is sent at index k.
- elem_count = 25; en=1.
REQ-038 Bad dimensions: start with r_in=6, c_in=2, and separately r_in=0.
- dim_err pulses one cycle; busy stays 0; elem_ready stays 0.
REQ-039 Abort in LOAD: abort after 3 of 9 elements of a 3x3 load.
- Next cycle: IDLE, elem_count=0, data_out all 0, en=0.
- A subsequent 1x1 load with value 511 gives data_out_0=511, en=1.
REQ-040 VALID hold and release:
- elem_valid and start pulses while en=1 change nothing.
- release gives en=0 and busy=0 next cycle, with data_out retained.
REQ-041 Async reset: drop reset_n between clock edges mid-LOAD.
- Outputs go to 0 immediately, without waiting for a clock edge.
- The load restarts cleanly after release.
